// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the seven-segment scan-bus blocks.
//   - SEG_A..SEG_DP : bit positions of each segment within the 8-bit segment field
//                     {dp,g,f,e,d,c,b,a}
//   - HEX_TABLE     : active-high gfedcba pattern for each hex digit 0..F
//   - frame_state_t : frame assembly states of the capture block
package sevenseg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry i is the lit-segment pattern for digit i. The bus carries the inverse.
   localparam logic [15:0][6:0] HEX_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT
   } frame_state_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// sevenseg_pattern_decode
// Combinational reverse lookup of one digit's segment pattern.
// Ports:
//   pattern  in  7  active-low gfedcba segment levels as seen on the bus
//   nibble   out 4  decoded hex value (0 when the pattern is unknown)
//   unknown  out 1  pattern matches no entry of the hex table
module sevenseg_pattern_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       unknown
);

   // Table entries are all distinct, so at most one comparison can hit.
   // Anything else, including all segments off, reports unknown with nibble 0.
   always_comb begin
      nibble  = 4'h0;
      unknown = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (pattern == ~HEX_TABLE[i]) begin
            nibble  = 4'(i);
            unknown = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture
// Receive side of the multiplexed seven-segment scan bus: synchronizes the
// bus, waits for each sample to be stable, decodes the lit segments back to a
// hex nibble and reassembles a full NUMCELLS-digit value.
// Parameters:
//   NUMCELLS       number of multiplexed digits (bus width 8+NUMCELLS)
//   STABLE_CYCLES  identical synchronized samples needed to accept a digit
//   TIMEOUT        cycles without a capture before stale asserts
// Ports:
//   clock        in   system clock, rising edge
//   rst          in   asynchronous reset, active-low
//   seg          in   scan bus: [7+NUMCELLS:8] active-low digit enables,
//                     [7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   value        out  last complete frame, digit k at [4k+3:4k]
//   frame_valid  out  one-cycle pulse as a new frame is emitted
//   pattern_err  out  per-digit unknown-pattern flags of the last frame
//   bus_err      out  one-cycle pulse after a stable sample with >1 enable low
//   stale        out  no digit captured for TIMEOUT cycles
//   dp           out  per-digit decimal point of the last frame (only with
//                     SEVENSEG_CAPTURE_DP_EN defined)
// Build option: define SEVENSEG_CAPTURE_DP_EN to capture decimal points and
// expose the dp port; otherwise seg[7] is ignored.
module sevenseg_capture
   import sevenseg_pkg::*;
#(
   parameter int NUMCELLS      = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 65536
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic [7+NUMCELLS:0]     seg,
   output logic [4*NUMCELLS-1:0]   value,
   output logic                    frame_valid,
   output logic [NUMCELLS-1:0]     pattern_err,
   output logic                    bus_err,
   output logic                    stale
`ifdef SEVENSEG_CAPTURE_DP_EN
   ,
   output logic [NUMCELLS-1:0]     dp
`endif
);

   localparam int W  = 8 + NUMCELLS;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [NUMCELLS-1:0] FULL_MASK = '1;

   logic [W-1:0]          segIn;
   logic [W-1:0]          s1, s2, s3;
   logic [CW-1:0]         stableCount;
   logic                  sameSample;
   logic                  accept;
   logic [NUMCELLS-1:0]   enables;
   logic                  noneLow, singleLow, multiLow;
   logic                  validAccept;
   logic                  complete;
   logic [3:0]            nibble;
   logic                  unknown;
   logic [NUMCELLS-1:0]   mask;
   logic [4*NUMCELLS-1:0] collect;
   logic [NUMCELLS-1:0]   pendErr;
   logic [TW-1:0]         idleCount;
   logic                  timeoutHit;
   frame_state_t          state, nextState;

   // Without the decimal-point option the dp line is forced inactive before
   // synchronizing, so its activity can neither disturb stability nor leak in.
`ifdef SEVENSEG_CAPTURE_DP_EN
   assign segIn = seg;
`else
   assign segIn = seg | W'(1 << SEG_DP);
`endif

   // Two-flop synchronizer plus one more stage holding the previous s2 sample
   // for the stability comparison. All-ones is the idle (blank) bus.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         s1 <= '1;
         s2 <= '1;
         s3 <= '1;
      end else begin
         s1 <= segIn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // stableCount holds the run length of identical s2 samples seen so far.
   // Acceptance is the one cycle on which that run reaches STABLE_CYCLES;
   // holding the bus beyond that saturates the count and never re-accepts.
   assign sameSample = (s2 == s3);
   assign accept     = sameSample ? (stableCount == CW'(STABLE_CYCLES - 1))
                                  : (STABLE_CYCLES == 1);

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         stableCount <= '0;
      end else if (!sameSample) begin
         stableCount <= CW'(1);
      end else if (stableCount != CW'(STABLE_CYCLES)) begin
         stableCount <= stableCount + CW'(1);
      end
   end

   // Classify the accepted sample by how many digit enables are low.
   assign enables     = ~s2[W-1:8];
   assign noneLow     = (enables == '0);
   assign singleLow   = !noneLow && ((enables & (enables - NUMCELLS'(1))) == '0);
   assign multiLow    = !noneLow && !singleLow;
   assign validAccept = accept && singleLow;
   assign complete    = ((mask | enables) == FULL_MASK);

   sevenseg_pattern_decode u_decode (
      .pattern (s2[SEG_G:SEG_A]),
      .nibble  (nibble),
      .unknown (unknown)
   );

   // Idle counter: cleared by every valid digit capture, otherwise counts up
   // and saturates. Reaching TIMEOUT flags stale and drops any partial frame.
   assign timeoutHit = !validAccept && (idleCount == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         idleCount <= '0;
         stale     <= 1'b0;
      end else begin
         if (validAccept) begin
            idleCount <= '0;
            stale     <= 1'b0;
         end else begin
            if (idleCount != TW'(TIMEOUT)) begin
               idleCount <= idleCount + TW'(1);
            end
            if (timeoutHit) begin
               stale <= 1'b1;
            end
         end
      end
   end

   // Frame state register.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. IDLE means an empty mask; EMIT lasts one cycle and is
   // where frame_valid is raised. An accept during EMIT starts the next frame.
   always_comb begin
      nextState   = state;
      frame_valid = 1'b0;
      case (state)
         IDLE: begin
            if (validAccept) begin
               nextState = complete ? EMIT : COLLECT;
            end
         end
         COLLECT: begin
            if (validAccept && complete) begin
               nextState = EMIT;
            end
         end
         EMIT: begin
            frame_valid = 1'b1;
            if (validAccept) begin
               nextState = (enables == FULL_MASK) ? EMIT : COLLECT;
            end else begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      if (timeoutHit) begin
         nextState = IDLE;
      end
   end

   // Digit collection. The mask restarts on EMIT (keeping a concurrent accept)
   // and on timeout. A repeated digit simply overwrites its slot.
`ifdef SEVENSEG_CAPTURE_DP_EN
   logic [NUMCELLS-1:0] collectDp;
`endif

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         mask    <= '0;
         collect <= '0;
         pendErr <= '0;
`ifdef SEVENSEG_CAPTURE_DP_EN
         collectDp <= '0;
`endif
      end else begin
         if (timeoutHit) begin
            mask <= '0;
         end else if (state == EMIT) begin
            mask <= validAccept ? enables : '0;
         end else if (validAccept) begin
            mask <= mask | enables;
         end
         if (validAccept) begin
            for (int k = 0; k < NUMCELLS; k++) begin
               if (enables[k]) begin
                  collect[4*k +: 4] <= nibble;
                  pendErr[k]        <= unknown;
`ifdef SEVENSEG_CAPTURE_DP_EN
                  collectDp[k]      <= ~s2[SEG_DP];
`endif
               end
            end
         end
      end
   end

   // Published frame. Loaded from the collect registers at the end of EMIT,
   // so a digit arriving in that same cycle belongs to the next frame.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         value       <= '0;
         pattern_err <= '0;
`ifdef SEVENSEG_CAPTURE_DP_EN
         dp          <= '0;
`endif
      end else if (state == EMIT) begin
         value       <= collect;
         pattern_err <= pendErr;
`ifdef SEVENSEG_CAPTURE_DP_EN
         dp          <= collectDp;
`endif
      end
   end

   // A stable sample with several enables low is flagged on the following cycle.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         bus_err <= 1'b0;
      end else begin
         bus_err <= accept && multiLow;
      end
   end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture
// Directed bench for sevenseg_capture (NUMCELLS=4, STABLE_CYCLES=4,
// TIMEOUT=64). Expected frames are queued as scans are driven and compared
// by a monitor when frame_valid fires. Define SEVENSEG_CAPTURE_DP_EN to also
// exercise the dp output.
module tb_sevenseg_capture;

   localparam int NC  = 4;
   localparam int STB = 4;
   localparam int TMO = 64;

   typedef struct {
      logic [15:0] v;
      logic [3:0]  pe;
      logic [3:0]  d;
   } frame_t;

   logic        clock;
   logic        rst;
   logic [11:0] seg;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  pattern_err;
   logic        bus_err;
   logic        stale;
`ifdef SEVENSEG_CAPTURE_DP_EN
   logic [3:0]  dp;
`endif

   int     checks      = 0;
   int     failures    = 0;
   int     frameCount  = 0;
   int     busErrCount = 0;
   bit     compareNow  = 0;
   frame_t expQ[$];

   sevenseg_capture #(
      .NUMCELLS      (NC),
      .STABLE_CYCLES (STB),
      .TIMEOUT       (TMO)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .seg         (seg),
      .value       (value),
      .frame_valid (frame_valid),
      .pattern_err (pattern_err),
      .bus_err     (bus_err),
      .stale       (stale)
`ifdef SEVENSEG_CAPTURE_DP_EN
      ,
      .dp          (dp)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one bus word (enables, segments) for dwell cycles.
   task automatic applyStimulus(input logic [3:0] en, input logic [7:0] segs,
                                input int dwell);
      @(negedge clock);
      seg = {en, segs};
      repeat (dwell - 1) @(negedge clock);
   endtask

   task automatic idleBus(input int n);
      applyStimulus(4'hF, 8'hFF, n);
   endtask

   task automatic expectFrame(input logic [15:0] v, input logic [3:0] pe,
                              input logic [3:0] d);
      frame_t f;
      f.v  = v;
      f.pe = pe;
      f.d  = d;
      expQ.push_back(f);
   endtask

   // Monitor: value/pattern_err/dp change at the edge ending the frame_valid
   // cycle, so they are compared one negedge after the pulse is seen.
   always @(negedge clock) begin
      if (compareNow) begin
         checkOutput("frame_expected", 32'(expQ.size() > 0), 32'd1);
         if (expQ.size() > 0) begin
            frame_t f;
            f = expQ.pop_front();
            checkOutput("frame_value", 32'(value), 32'(f.v));
            checkOutput("frame_pattern_err", 32'(pattern_err), 32'(f.pe));
`ifdef SEVENSEG_CAPTURE_DP_EN
            checkOutput("frame_dp", 32'(dp), 32'(f.d));
`endif
         end
      end
      compareNow = rst && frame_valid;
      if (frame_valid) frameCount++;
      if (bus_err) busErrCount++;
   end

   initial begin
      int frames0;
      int errs0;
      bit sawStale;

      rst = 1'b0;
      seg = '1;
      repeat (3) @(negedge clock);

      // Reset state while held in reset.
      checkOutput("reset_value", 32'(value), 32'h0);
      checkOutput("reset_frame_valid", 32'(frame_valid), 32'h0);
      checkOutput("reset_pattern_err", 32'(pattern_err), 32'h0);
      checkOutput("reset_bus_err", 32'(bus_err), 32'h0);
      checkOutput("reset_stale", 32'(stale), 32'h0);
`ifdef SEVENSEG_CAPTURE_DP_EN
      checkOutput("reset_dp", 32'(dp), 32'h0);
`endif
      rst = 1'b1;
      idleBus(4);

      // Clean scan 0,1,2,3.
      $display("[TB] clean scan");
      expectFrame(16'h3210, 4'b0000, 4'b0000);
      applyStimulus(4'b1110, 8'hC0, 8);
      applyStimulus(4'b1101, 8'hF9, 8);
      applyStimulus(4'b1011, 8'hA4, 8);
      applyStimulus(4'b0111, 8'hB0, 8);
      idleBus(16);
      checkOutput("clean_frame_count", 32'(frameCount), 32'd1);

      // Short glitch (5) on digit 2 must never be accepted; 8 is.
      $display("[TB] glitch scan");
      expectFrame(16'h3810, 4'b0000, 4'b0000);
      applyStimulus(4'b1110, 8'hC0, 8);
      applyStimulus(4'b1101, 8'hF9, 8);
      applyStimulus(4'b1011, 8'h92, 2);
      applyStimulus(4'b1011, 8'h80, 8);
      applyStimulus(4'b0111, 8'hB0, 8);
      idleBus(16);
      checkOutput("glitch_frame_count", 32'(frameCount), 32'd2);

      // Two enables low mid-frame: one bus_err, frame unaffected.
      $display("[TB] bus error scan");
      errs0 = busErrCount;
      expectFrame(16'h3210, 4'b0000, 4'b0000);
      applyStimulus(4'b1110, 8'hC0, 8);
      applyStimulus(4'b1101, 8'hF9, 8);
      applyStimulus(4'b1100, 8'hC0, 8);
      applyStimulus(4'b1011, 8'hA4, 8);
      applyStimulus(4'b0111, 8'hB0, 8);
      idleBus(16);
      checkOutput("bus_err_pulses", 32'(busErrCount - errs0), 32'd1);
      checkOutput("bus_err_frame_count", 32'(frameCount), 32'd3);

      // Blank digit 1 decodes as 0 with a pattern error.
      $display("[TB] blank digit scan");
      expectFrame(16'h3200, 4'b0010, 4'b0000);
      applyStimulus(4'b1110, 8'hC0, 8);
      applyStimulus(4'b1101, 8'hFF, 8);
      applyStimulus(4'b1011, 8'hA4, 8);
      applyStimulus(4'b0111, 8'hB0, 8);
      idleBus(16);
      checkOutput("blank_frame_count", 32'(frameCount), 32'd4);

      // Partial scan then silence: stale asserts, no frame, value retained.
      $display("[TB] timeout");
      frames0 = frameCount;
      applyStimulus(4'b1110, 8'hC0, 8);
      applyStimulus(4'b1101, 8'hF9, 8);
      applyStimulus(4'b1011, 8'hA4, 8);
      idleBus(20);
      checkOutput("stale_not_early", 32'(stale), 32'h0);
      sawStale = 0;
      for (int i = 0; i < TMO + 40; i++) begin
         @(negedge clock);
         if (stale) begin
            sawStale = 1;
            break;
         end
      end
      checkOutput("stale_asserted", 32'(sawStale), 32'h1);
      checkOutput("stale_no_frame", 32'(frameCount - frames0), 32'd0);
      checkOutput("stale_value_kept", 32'(value), 32'h3200);

      // Restart beginning with digit 3: the partial frame must be gone.
      expectFrame(16'h7654, 4'b0000, 4'b0000);
      applyStimulus(4'b0111, 8'hF8, 8);
      checkOutput("stale_cleared", 32'(stale), 32'h0);
      applyStimulus(4'b1110, 8'h99, 8);
      applyStimulus(4'b1101, 8'h92, 8);
      applyStimulus(4'b1011, 8'h82, 8);
      idleBus(16);
      checkOutput("restart_frame_count", 32'(frameCount - frames0), 32'd1);

      // Reset mid-frame discards partial digits.
      $display("[TB] reset mid-frame");
      applyStimulus(4'b1110, 8'h82, 8);
      applyStimulus(4'b1101, 8'h80, 8);
      rst = 1'b0;
      @(negedge clock);
      checkOutput("midreset_value", 32'(value), 32'h0);
      checkOutput("midreset_pattern_err", 32'(pattern_err), 32'h0);
      checkOutput("midreset_stale", 32'(stale), 32'h0);
      repeat (2) @(negedge clock);
      rst = 1'b1;
      frames0 = frameCount;
      expectFrame(16'h3210, 4'b0000, 4'b0001);
      applyStimulus(4'b1110, 8'h40, 8);
      applyStimulus(4'b1101, 8'hF9, 8);
      applyStimulus(4'b1011, 8'hA4, 8);
      applyStimulus(4'b0111, 8'hB0, 8);
      idleBus(16);
      checkOutput("postreset_frame_count", 32'(frameCount - frames0), 32'd1);

      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      checkOutput("total_bus_err", 32'(busErrCount), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
